// File: rtl/VX_gpu_pkg.sv
// Shared commit-path definitions: source index map, commit beat layout and lock states.
package VX_gpu_pkg;

   localparam int COMMIT_SRC_ALU = 0;
   localparam int COMMIT_SRC_LSU = 1;
   localparam int COMMIT_SRC_FPU = 2;
   localparam int COMMIT_SRC_SFU = 3;

   localparam int COMMIT_DATA_W  = 128;
   localparam int COMMIT_SRC_W   = 2;

   // Field order matches the packing used inside the arbiter's elastic buffer.
   typedef struct packed {
      logic [COMMIT_DATA_W-1:0] data;
      logic                     sop;
      logic                     eop;
      logic [COMMIT_SRC_W-1:0]  src;
   } commit_beat_t;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

endpackage

// File: rtl/vx_commit_elastic_buf.sv
// Two-entry elastic FIFO with a registered not-full flag, so in_ready_o never
// depends combinationally on out_ready_i.
module vx_commit_elastic_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   output logic         in_ready_o,
   output logic         out_valid_o,
   output logic [W-1:0] out_data_o,
   input  logic         out_ready_i
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic         not_full_q;
   logic         push;
   logic         pop;

   assign push        = in_valid_i && not_full_q;
   assign pop         = (count_q != 2'd0) && out_ready_i;
   assign in_ready_o  = not_full_q;
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the storage is reset too, because the head drives the outputs and must read zero after reset.
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         not_full_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
         end
         wr_ptr_q   <= wr_ptr_q ^ push;
         rd_ptr_q   <= rd_ptr_q ^ pop;
         count_q    <= count_d;
         not_full_q <= (count_d != 2'd2);
      end
   end

endmodule

// File: rtl/vx_commit_arb.sv
// Per-issue-slot commit arbiter: round-robin, packet-locked merge of the
// ALU/LSU/FPU/SFU commit streams into one registered writeback stream.
module vx_commit_arb
   import VX_gpu_pkg::*;
#(
   parameter int NUM_SRCS = 4,
   parameter int DATA_W   = 128,
   parameter int CNT_W    = 32,
   localparam int SRC_W   = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_SRCS-1:0]        src_valid,
   input  logic [NUM_SRCS*DATA_W-1:0] src_data,
   input  logic [NUM_SRCS-1:0]        src_sop,
   input  logic [NUM_SRCS-1:0]        src_eop,
   output logic [NUM_SRCS-1:0]        src_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_sop,
   output logic                       out_eop,
   output logic [SRC_W-1:0]           out_src,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           retired_cnt
);

   localparam int BEAT_W = DATA_W + 2 + SRC_W;

   lock_state_e       state_q, state_d;
   logic [SRC_W-1:0]  locked_src_q, locked_src_d;
   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  retired_q;

   logic [SRC_W-1:0]  grant;
   logic              grant_valid;
   int                idx;
   logic              can_accept;
   logic              sel_valid;
   logic              sel_sop;
   logic              sel_eop;
   logic [DATA_W-1:0] sel_data;
   logic              accept;
   logic [BEAT_W-1:0] buf_in;
   logic [BEAT_W-1:0] buf_out;

   // While a packet is open the locked source keeps the grant; otherwise search
   // upward from rr_ptr and wrap.
   always_comb begin
      grant       = rr_ptr_q;
      grant_valid = 1'b0;
      idx         = 0;
      if (state_q == LOCKED) begin
         grant       = locked_src_q;
         grant_valid = 1'b1;
      end else begin
         for (int k = 0; k < NUM_SRCS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRCS) begin
               idx = idx - NUM_SRCS;
            end
            if (!grant_valid && src_valid[SRC_W'(idx)]) begin
               grant       = SRC_W'(idx);
               grant_valid = 1'b1;
            end
         end
      end
   end

   assign sel_valid = src_valid[grant];
   assign sel_sop   = src_sop[grant];
   assign sel_eop   = src_eop[grant];
   assign sel_data  = src_data[int'(grant)*DATA_W +: DATA_W];
   assign accept    = grant_valid && sel_valid && can_accept;
   assign buf_in    = {sel_data, sel_sop, sel_eop, grant};

   always_comb begin
      src_ready = '0;
      if (grant_valid && can_accept) begin
         src_ready[grant] = 1'b1;
      end
   end

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      locked_src_d = locked_src_q;
      rr_ptr_d     = rr_ptr_q;
      if (accept) begin
         case (state_q)
            UNLOCKED: begin
               if (!sel_eop) begin
                  state_d      = LOCKED;
                  locked_src_d = grant;
               end
            end
            LOCKED: begin
               if (sel_eop) begin
                  state_d = UNLOCKED;
               end
            end
            default: state_d = UNLOCKED;
         endcase
         if (sel_eop) begin
            rr_ptr_d = (grant == SRC_W'(NUM_SRCS - 1)) ? '0 : grant + SRC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q      <= UNLOCKED;
         locked_src_q <= '0;
         rr_ptr_q     <= SRC_W'(COMMIT_SRC_ALU);
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         locked_src_q <= locked_src_d;
         rr_ptr_q     <= rr_ptr_d;
         if (out_valid && out_ready && out_eop) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   vx_commit_elastic_buf #(
      .W (BEAT_W)
   ) u_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid_i  (grant_valid && sel_valid),
      .in_data_i   (buf_in),
      .in_ready_o  (can_accept),
      .out_valid_o (out_valid),
      .out_data_o  (buf_out),
      .out_ready_i (out_ready)
   );

   assign {out_data, out_sop, out_eop, out_src} = buf_out;
   assign retired_cnt = retired_q;

`ifndef SYNTHESIS
   // A new sop inside an open packet is passed through as data; flag it here.
   sop_inside_packet: assert property (@(posedge clk) disable iff (!reset_n)
      !(accept && (state_q == LOCKED) && sel_sop))
      else $error("sop from locked source %0d inside an open packet", locked_src_q);
`endif

endmodule

// File: doc/vx_commit_arb.md
Name: vx_commit_arb

Overview:
- Per-issue-slot commit arbiter directly downstream of the execute stage.
- Merges the ALU, LSU, FPU and SFU commit streams of one issue slot into a single writeback/commit stream for the register-file writeback and scoreboard release.
- Arbitration is round-robin and packet-locked, so multi-beat commits (sop..eop) are never interleaved.
- The output is registered through a 2-entry elastic buffer, so there is no combinational path from out_ready to src_ready.

Parameters:
- NUM_SRCS, 4, number of commit sources (index 0=ALU, 1=LSU, 2=FPU, 3=SFU).
- DATA_W, 128, width of one commit payload (wid, tmask, PC, wb, rd, lane data), opaque to this block.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRCS  per-source commit valid
- src_data  in  NUM_SRCS*DATA_W  flattened payloads; source i occupies [i*DATA_W +: DATA_W]
- src_sop  in  NUM_SRCS  first beat of a packet
- src_eop  in  NUM_SRCS  last beat of a packet
- src_ready  out  NUM_SRCS  per-source accept
- out_valid  out  1  commit valid
- out_data  out  DATA_W  payload
- out_sop  out  1  first beat
- out_eop  out  1  last beat
- out_src  out  $clog2(NUM_SRCS)  originating source index
- out_ready  in  1  downstream accept
- retired_cnt  out  CNT_W  count of committed packets (eop handshakes at output)

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous and active-low. All state clears on reset_n low regardless of clk.
- Reset values: out_valid=0, out_data=0, out_sop=0, out_eop=0, out_src=0, src_ready=0, retired_cnt=0, rr_ptr=0, lock=0, buffer empty.
- Buffer: 2-entry FIFO of {data, sop, eop, src}. `can_accept` = registered "count<2", true after reset deassertion. out_valid = (count!=0). Head drives out_*.
- Eligibility: if lock=1, only locked_src is eligible. Otherwise every i with src_valid[i] is eligible.
- Grant: the first eligible index at or after rr_ptr, searching upward and wrapping modulo NUM_SRCS. Computed combinationally.
- src_ready[g] = can_accept && (grant valid). All other src_ready bits are 0. A source's ready never depends on its own valid beyond grant selection.
- Accept (src_valid[g] && src_ready[g]) pushes the beat. Latency is 1 cycle: an accepted beat appears on out_* the next cycle if the buffer was empty.
- Lock FSM, states UNLOCKED/LOCKED:
  - UNLOCKED: accept with !eop -> LOCKED, locked_src=g.
  - LOCKED: accept with eop -> UNLOCKED.
  - Any accept with eop sets rr_ptr = (g+1) mod NUM_SRCS. A beat with sop&eop is a single-beat packet: no lock, pointer advances.
  - Beats with !eop never move rr_ptr.
- Protocol violation: sop arriving while LOCKED from the locked source is accepted as data (no check). An assertion flags it in simulation only.
- Simultaneous push and pop with count=2: not possible, since can_accept was 0. With count=1, push and pop keep count=1.
- Pop: out_valid && out_ready. On a pop with out_eop=1, retired_cnt += 1, wrapping modulo 2^CNT_W.
- Held output: out_data/out_sop/out_eop/out_src stay stable while out_valid && !out_ready.
- Reset mid-packet: lock cleared, buffered beats discarded, retired_cnt=0. Upstream must restart at sop.

Decomposition:
- Shared package (VX_gpu_pkg): source index constants COMMIT_SRC_ALU/LSU/FPU/SFU and the commit_beat_t struct {data, sop, eop, src}.
- Sub-module vx_commit_elastic_buf: the parameterised 2-entry FIFO with a registered not-full flag. It is reusable for the dispatch side.
- Arbitration, lock FSM and counter live in vx_commit_arb.

Test Plan:
- Reset: hold reset_n=0 with src_valid=4'b1111 -> src_ready=0, out_valid=0, retired_cnt=0. First cycle after release: src_ready=4'b0001.
- Round-robin fairness: all four sources continuously valid with single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0 and retired_cnt=5 after 5 pops.
- Packet lock: LSU sends 3 beats (sop, -, eop) while ALU stays valid -> out_src=1 for 3 consecutive beats, then 0 (rr_ptr wraps to 2; next eligible from 2 is 0). retired_cnt increments by 1 only.
- Backpressure: out_ready=0 for 5 cycles with source 2 valid -> exactly 2 beats accepted, src_ready drops to 0 from the 3rd cycle, out_data stays stable. Releasing out_ready drains in order.
- Counter wrap: CNT_W=4, 17 eop pops -> retired_cnt=1.
- Async reset mid-packet: reset_n pulsed low between beat 1 and beat 2 of an SFU packet, off a clock edge -> outputs clear immediately. After release, ALU (index 0) is granted first with no lock.
